image_rx_packer: RTL and testbench

Parametrised successor to the single-format RIFFA RX image controller. Receives one frame per RIFFA RX transaction, checks the length against the configured WIDTH×HEIGHT, and converts pixels to RGB565 or passes them through as 32-bit. Packs pixels into OUT_WIDTH words in an internal FIFO and streams them to the DDR write path in BURST_LEN bursts, ending each frame with a flushed short burst. Sits between the RIFFA channel and the frame-buffer write arbiter.

---
 rtl/image_rx_packer.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_image_rx_packer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_rx_packer.sv
// ---------------------------------------------------------------------------
// image_rx_packer
//
// Receives one image frame per RIFFA RX transaction, checks its length
// against the configured WIDTH x HEIGHT, converts each pixel to RGB565
// (PIX_MODE=0) or keeps it as 32 bits (PIX_MODE=1), packs the pixels into
// OUT_WIDTH words in a first-word-fall-through FIFO and streams them out in
// bursts of BURST_LEN words. Each frame ends with a flushed short burst.
//
// Parameters
//   C_PCI_DATA_WIDTH  RIFFA data width (32, 64 or 128)
//   OUT_WIDTH         output word width, a multiple of C_PCI_DATA_WIDTH
//   BURST_LEN         words per full burst (>= 2)
//   FIFO_DEPTH        FIFO depth in words, power of two, >= 2*BURST_LEN
//
// Ports
//   CLK, RST                    clock, synchronous active-high reset
//   CHNL_RX_CLK                 copy of CLK for the RIFFA channel
//   CHNL_RX / CHNL_RX_ACK       transaction request / one-cycle acknowledge
//   CHNL_RX_LAST, CHNL_RX_OFF   unused
//   CHNL_RX_LEN                 transaction length in DW
//   CHNL_RX_DATA/_VALID/_REN    pixel beats; lowest DW is the earliest pixel
//   CONF_END, WIDTH, HEIGHT,    configuration, latched while idle
//   PIX_MODE
//   WR_EN/WR_RDY/WR_DATA/WR_LAST  burst output; earliest pixel in the LSBs
//   FRAME_END                   pulse after the last word of a frame is taken
//   LEN_ERR                     pulse when a transaction is rejected
//   FRAME_CNT, ERR_CNT          statistics, present only with the
//                               IMAGE_RX_STATS_EN macro defined
//
// Handshakes: a RIFFA beat transfers on a cycle where CHNL_RX_DATA_VALID and
// CHNL_RX_DATA_REN are both high; an output word transfers on a cycle where
// WR_EN and WR_RDY are both high. Neither side may retract data before the
// transfer cycle.
// ---------------------------------------------------------------------------
module image_rx_packer #(
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int OUT_WIDTH        = 128,
    parameter int BURST_LEN        = 64,
    parameter int FIFO_DEPTH       = 1024
) (
    input  logic                        CLK,
    input  logic                        RST,
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN,
    input  logic                        CONF_END,
    input  logic [15:0]                 WIDTH,
    input  logic [15:0]                 HEIGHT,
    input  logic                        PIX_MODE,
    output logic                        WR_EN,
    input  logic                        WR_RDY,
    output logic [OUT_WIDTH-1:0]        WR_DATA,
    output logic                        WR_LAST,
    output logic                        FRAME_END,
`ifdef IMAGE_RX_STATS_EN
    output logic                        LEN_ERR,
    output logic [15:0]                 FRAME_CNT,
    output logic [15:0]                 ERR_CNT
`else
    output logic                        LEN_ERR
`endif
);

    localparam int K    = C_PCI_DATA_WIDTH / 32;   // DW per beat
    localparam int KSH  = $clog2(K);
    localparam int POSW = $clog2(OUT_WIDTH + 1);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int BLW  = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  len_err_q, len_err_d;
    logic                  ren_q, ren_d;
    logic                  frame_end_q, frame_end_d;
    logic [31:0]           exp_dw_q, exp_dw_d;
    logic                  mode_q, mode_d;
    logic [31:0]           total_q, total_d;
    logic [31:0]           beat_cnt_q, beat_cnt_d;
    logic [OUT_WIDTH-1:0]  pack_q, pack_d;
    logic [POSW-1:0]       pos_q, pos_d;
    logic                  burst_q, burst_d;
    logic [BLW-1:0]        left_q, left_d;
    logic [CNTW-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OUT_WIDTH-1:0]  mem [FIFO_DEPTH];

    logic                       beat;
    logic                       push;
    logic                       pop;
    logic                       afull;
    logic                       frame_last_pop;
    logic [OUT_WIDTH-1:0]       push_data;
    logic [OUT_WIDTH-1:0]       chunk;
    logic [POSW-1:0]            chunk_bits;
    logic [C_PCI_DATA_WIDTH/2-1:0] conv;
    logic [32:0]                total_tmp;
    logic                       unused_inputs;

    assign unused_inputs = ^{CHNL_RX_LAST, CHNL_RX_OFF};

    // RGB565 conversion of every DW in the beat, keeping DW order.
    always_comb begin
        conv = '0;
        for (int i = 0; i < K; i++) begin
            conv[i*16 +: 16] = {CHNL_RX_DATA[i*32+19 +: 5],
                                CHNL_RX_DATA[i*32+10 +: 6],
                                CHNL_RX_DATA[i*32+3  +: 5]};
        end
    end

    assign chunk      = mode_q ? OUT_WIDTH'(CHNL_RX_DATA) : OUT_WIDTH'(conv);
    assign chunk_bits = mode_q ? POSW'(C_PCI_DATA_WIDTH) : POSW'(C_PCI_DATA_WIDTH / 2);

    assign beat  = CHNL_RX_DATA_VALID & ren_q;
    assign pop   = burst_q & WR_RDY;
    // REN is registered, so one extra beat can land after afull rises; the
    // 4-word margin covers that beat plus the packer residue pushed in FLUSH.
    assign afull = 32'(fifo_cnt_q) >= 32'(FIFO_DEPTH - 4);
    // In FLUSH with the packer empty no more pushes can happen, so the pop
    // that ends a burst while one word is left is the last word of the frame.
    assign frame_last_pop = pop && (left_q == BLW'(1)) && (fifo_cnt_q == CNTW'(1));

    // Beats needed to cover LEN DW, rounded up for the drain path.
    assign total_tmp = {1'b0, CHNL_RX_LEN} + 33'(K - 1);

    // Receive FSM and packer.
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        len_err_d   = 1'b0;
        ren_d       = 1'b0;
        frame_end_d = 1'b0;
        exp_dw_d    = exp_dw_q;
        mode_d      = mode_q;
        total_d     = total_q;
        beat_cnt_d  = beat_cnt_q;
        pack_d      = pack_q;
        pos_d       = pos_q;
        push        = 1'b0;
        push_data   = pack_q;

        case (state_q)
            IDLE: begin
                if (CONF_END) begin
                    exp_dw_d = 32'(WIDTH) * 32'(HEIGHT);
                    mode_d   = PIX_MODE;
                end
                if (CHNL_RX) begin
                    ack_d      = 1'b1;
                    total_d    = 32'(total_tmp >> KSH);
                    beat_cnt_d = '0;
                    if ((CHNL_RX_LEN == exp_dw_q) && (CHNL_RX_LEN != 32'd0) &&
                        ((CHNL_RX_LEN & 32'(K - 1)) == 32'd0)) begin
                        state_d = RECV;
                    end else begin
                        len_err_d = 1'b1;
                        state_d   = DRAIN;
                    end
                end
            end

            RECV: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    pack_d     = pack_q | (chunk << pos_q);
                    pos_d      = pos_q + chunk_bits;
                    if (pos_d == POSW'(OUT_WIDTH)) begin
                        push      = 1'b1;
                        push_data = pack_d;
                        pack_d    = '0;
                        pos_d     = '0;
                    end
                    if (beat_cnt_d == total_q) begin
                        state_d = FLUSH;
                    end
                end
                ren_d = (state_d == RECV) && !afull;
            end

            DRAIN: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                end
                if (!CHNL_RX || (beat_cnt_d >= total_q)) begin
                    state_d = IDLE;
                end else begin
                    ren_d = 1'b1;
                end
            end

            FLUSH: begin
                if (pos_q != '0) begin
                    // Residue is already zero above pos_q.
                    push      = 1'b1;
                    push_data = pack_q;
                    pack_d    = '0;
                    pos_d     = '0;
                end else if (frame_last_pop) begin
                    frame_end_d = 1'b1;
                    state_d     = IDLE;
                end else if ((fifo_cnt_q == '0) && !burst_q) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Burst engine and FIFO pointers.
    always_comb begin
        burst_d    = burst_q;
        left_d     = left_q;
        fifo_cnt_d = fifo_cnt_q + CNTW'(push) - CNTW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);

        if (burst_q) begin
            if (pop) begin
                left_d = left_q - BLW'(1);
                if (left_q == BLW'(1)) begin
                    burst_d = 1'b0;
                end
            end
        end else if (32'(fifo_cnt_q) >= 32'(BURST_LEN)) begin
            burst_d = 1'b1;
            left_d  = BLW'(BURST_LEN);
        end else if ((state_q == FLUSH) && (pos_q == '0) && (fifo_cnt_q != '0)) begin
            burst_d = 1'b1;
            left_d  = BLW'(fifo_cnt_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            len_err_q   <= 1'b0;
            ren_q       <= 1'b0;
            frame_end_q <= 1'b0;
            exp_dw_q    <= '0;
            mode_q      <= 1'b0;
            total_q     <= '0;
            beat_cnt_q  <= '0;
            pack_q      <= '0;
            pos_q       <= '0;
            burst_q     <= 1'b0;
            left_q      <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            len_err_q   <= len_err_d;
            ren_q       <= ren_d;
            frame_end_q <= frame_end_d;
            exp_dw_q    <= exp_dw_d;
            mode_q      <= mode_d;
            total_q     <= total_d;
            beat_cnt_q  <= beat_cnt_d;
            pack_q      <= pack_d;
            pos_q       <= pos_d;
            burst_q     <= burst_d;
            left_q      <= left_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign CHNL_RX_CLK      = CLK;
    assign CHNL_RX_ACK      = ack_q;
    assign CHNL_RX_DATA_REN = ren_q;
    assign LEN_ERR          = len_err_q;
    assign FRAME_END        = frame_end_q;
    assign WR_EN            = burst_q;
    assign WR_LAST          = burst_q && (left_q == BLW'(1));
    assign WR_DATA          = burst_q ? mem[rd_ptr_q] : '0;

`ifdef IMAGE_RX_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(frame_end_q);
        err_cnt_d   = err_cnt_q + 16'(len_err_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign FRAME_CNT = frame_cnt_q;
    assign ERR_CNT   = err_cnt_q;
`endif

endmodule

// File: tb/tb_image_rx_packer.sv
// ---------------------------------------------------------------------------
// tb_image_rx_packer
//
// Directed bench for image_rx_packer with a 64-bit channel, 128-bit output
// words, 16-word bursts and a 32-word FIFO. Output words are collected by a
// monitor and compared in order against words packed by the bench from the
// same pixel pattern it drives.
// ---------------------------------------------------------------------------
module tb_image_rx_packer;

    localparam int DWW = 64;
    localparam int OW  = 128;
    localparam int BL  = 16;
    localparam int FD  = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic           chnl_rx_clk;
    logic           chnl_rx;
    logic           chnl_rx_ack;
    logic           chnl_rx_last;
    logic [31:0]    chnl_rx_len;
    logic [30:0]    chnl_rx_off;
    logic [DWW-1:0] chnl_rx_data;
    logic           chnl_rx_data_valid;
    logic           chnl_rx_data_ren;
    logic           conf_end;
    logic [15:0]    width;
    logic [15:0]    height;
    logic           pix_mode;
    logic           wr_en;
    logic           wr_rdy;
    logic [OW-1:0]  wr_data;
    logic           wr_last;
    logic           frame_end;
    logic           len_err;
`ifdef IMAGE_RX_STATS_EN
    logic [15:0]    frame_cnt;
    logic [15:0]    err_cnt;
`endif

    image_rx_packer #(
        .C_PCI_DATA_WIDTH (DWW),
        .OUT_WIDTH        (OW),
        .BURST_LEN        (BL),
        .FIFO_DEPTH       (FD)
    ) dut (
        .CLK                (clk),
        .RST                (rst),
        .CHNL_RX_CLK        (chnl_rx_clk),
        .CHNL_RX            (chnl_rx),
        .CHNL_RX_ACK        (chnl_rx_ack),
        .CHNL_RX_LAST       (chnl_rx_last),
        .CHNL_RX_LEN        (chnl_rx_len),
        .CHNL_RX_OFF        (chnl_rx_off),
        .CHNL_RX_DATA       (chnl_rx_data),
        .CHNL_RX_DATA_VALID (chnl_rx_data_valid),
        .CHNL_RX_DATA_REN   (chnl_rx_data_ren),
        .CONF_END           (conf_end),
        .WIDTH              (width),
        .HEIGHT             (height),
        .PIX_MODE           (pix_mode),
        .WR_EN              (wr_en),
        .WR_RDY             (wr_rdy),
        .WR_DATA            (wr_data),
        .WR_LAST            (wr_last),
        .FRAME_END          (frame_end),
`ifdef IMAGE_RX_STATS_EN
        .LEN_ERR            (len_err),
        .FRAME_CNT          (frame_cnt),
        .ERR_CNT            (err_cnt)
`else
        .LEN_ERR            (len_err)
`endif
    );

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_err = 0;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] got_q[$];
    logic          got_last_q[$];
    int            fe_cnt = 0;
    int            le_cnt = 0;
    int            fe_words = 0;
    logic          fe_after_accept = 1'b0;
    logic          prev_acc = 1'b0;
    int            beat_idx = 0;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: a word transfers at the posedge following a negedge
    // that shows WR_EN & WR_RDY.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en && wr_rdy) begin
                got_q.push_back(wr_data);
                got_last_q.push_back(wr_last);
            end
            if (frame_end) begin
                fe_cnt++;
                fe_after_accept = prev_acc;
                fe_words = got_q.size();
            end
            if (len_err) le_cnt++;
            prev_acc = wr_en && wr_rdy;
            n_cmp++;
            assert ((dut.fifo_cnt_q <= FD) && !(wr_en && dut.fifo_cnt_q == 0)) else begin
                n_err++;
                $error("FAIL fifo_bounds: observed count %0d wr_en %0d expected 0..%0d, non-empty when popping",
                       dut.fifo_cnt_q, wr_en, FD);
            end
        end
    end

    // ---------------- model helpers ----------------
    function automatic logic [31:0] pix(input int i);
        pix = {8'h5A, 8'(i * 3), 8'(i * 5 + 8), 8'(i * 7 + 16)};
    endfunction

    function automatic logic [15:0] rgb565(input logic [31:0] dw);
        rgb565 = {dw[23:19], dw[15:10], dw[7:3]};
    endfunction

    task automatic build_exp(input int ndw, input bit mode);
        logic [OW-1:0] acc;
        logic [31:0]   p;
        int            pos;
        exp_q.delete();
        acc = '0;
        pos = 0;
        for (int i = 0; i < ndw; i++) begin
            p = pix(i);
            if (mode) begin
                acc[pos +: 32] = p;
                pos += 32;
            end else begin
                acc[pos +: 16] = rgb565(p);
                pos += 16;
            end
            if (pos == OW) begin
                exp_q.push_back(acc);
                acc = '0;
                pos = 0;
            end
        end
        if (pos != 0) exp_q.push_back(acc);
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_sb();
        got_q.delete();
        got_last_q.delete();
        fe_cnt = 0;
        le_cnt = 0;
        fe_words = 0;
        fe_after_accept = 1'b0;
    endtask

    task automatic configure(input int w, input int h, input bit mode);
        @(negedge clk);
        width = 16'(w);
        height = 16'(h);
        pix_mode = mode;
        conf_end = 1'b1;
        @(negedge clk);
        conf_end = 1'b0;
    endtask

    task automatic start_rx(input int len, output int lat);
        @(negedge clk);
        chnl_rx = 1'b1;
        chnl_rx_len = 32'(len);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!chnl_rx_ack && lat < 20);
        check("ack_seen", chnl_rx_ack, 1'b1);
        beat_idx = 0;
    endtask

    task automatic drive_beats(input int n, input int budget, input bit fin);
        int t;
        t = 0;
        while (beat_idx < n && t < budget) begin
            @(negedge clk);
            t++;
            chnl_rx_data = {pix(2 * beat_idx + 1), pix(2 * beat_idx)};
            chnl_rx_data_valid = 1'b1;
            if (chnl_rx_data_ren) beat_idx++;
        end
        if (fin) begin
            @(negedge clk);
            chnl_rx_data_valid = 1'b0;
            chnl_rx = 1'b0;
            check("beats_done", beat_idx, n);
        end
    endtask

    task automatic wait_frame_end(input int budget);
        int t;
        t = 0;
        while (fe_cnt == 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        check("frame_end_once", fe_cnt, 1);
        check("frame_end_after_accept", fe_after_accept, 1'b1);
    endtask

    task automatic check_words(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_data"}, got_q[i], exp_q[i]);
            check({tag, "_last"}, got_last_q[i],
                  (((i + 1) % BL) == 0) || (i == exp_q.size() - 1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"}, chnl_rx_ack, 1'b0);
        check({tag, "_ren"}, chnl_rx_data_ren, 1'b0);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_wr_last"}, wr_last, 1'b0);
        check({tag, "_frame_end"}, frame_end, 1'b0);
        check({tag, "_len_err"}, len_err, 1'b0);
        check({tag, "_wr_data"}, wr_data, '0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [OW-1:0] w;
        int            lat;

        rst = 1'b1;
        chnl_rx = 1'b0;
        chnl_rx_last = 1'b1;
        chnl_rx_len = '0;
        chnl_rx_off = '0;
        chnl_rx_data = '0;
        chnl_rx_data_valid = 1'b0;
        conf_end = 1'b0;
        width = '0;
        height = '0;
        pix_mode = 1'b0;
        wr_rdy = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // 16x4 RGB565 frame: 8 words in one burst
        configure(16, 4, 1'b0);
        build_exp(64, 1'b0);
        clear_sb();
        start_rx(64, lat);
        check("ack_latency", lat, 1);
        @(negedge clk);
        check("ack_one_cycle", chnl_rx_ack, 1'b0);
        check("ren_latency", chnl_rx_data_ren, 1'b1);
        drive_beats(32, 200, 1'b1);
        wait_frame_end(300);
        check_words("f16x4");
        w = (got_q.size() > 0) ? got_q[0] : '0;
        check("f16x4_px0", w[15:0], 16'h0042);
        check("f16x4_px1", w[31:16], 16'h0062);
        check("f16x4_fe_words", fe_words, 8);
        check("f16x4_no_len_err", le_cnt, 0);

        // 24x4 pass-through frame: bursts of 16 and 8
        configure(24, 4, 1'b1);
        build_exp(96, 1'b1);
        clear_sb();
        start_rx(96, lat);
        drive_beats(48, 300, 1'b1);
        wait_frame_end(300);
        check_words("f24x4");
        w = (got_q.size() > 0) ? got_q[0] : '0;
        check("f24x4_word0_lo", w[63:0], 64'h5A030D17_5A000810);

        // 3x3 frame: odd DW count is rejected and drained
        configure(3, 3, 1'b0);
        clear_sb();
        start_rx(9, lat);
        drive_beats(5, 100, 1'b1);
        check("drain_ren_dropped", chnl_rx_data_ren, 1'b0);
        repeat (20) @(negedge clk);
        check("drain_len_err", le_cnt, 1);
        check("drain_no_words", got_q.size(), 0);
        check("drain_no_frame_end", fe_cnt, 0);
`ifdef IMAGE_RX_STATS_EN
        check("drain_err_cnt", err_cnt, 16'd1);
`endif

        // 10x2 frame: third word is half padded
        configure(10, 2, 1'b0);
        build_exp(20, 1'b0);
        clear_sb();
        start_rx(20, lat);
        drive_beats(10, 100, 1'b1);
        wait_frame_end(300);
        check_words("f10x2");
        check("f10x2_fe_words", fe_words, 3);
        w = (got_q.size() > 2) ? got_q[2] : '1;
        check("f10x2_pad", w[127:64], 64'h0);

        // 32x4 pass-through frame with the output stalled: REN backs off
        configure(32, 4, 1'b1);
        build_exp(128, 1'b1);
        clear_sb();
        wr_rdy = 1'b0;
        start_rx(128, lat);
        drive_beats(64, 100, 1'b0);
        check("afull_beats", beat_idx, 57);
        check("afull_ren_low", chnl_rx_data_ren, 1'b0);
        check("afull_fifo_cnt", dut.fifo_cnt_q, 28);
        check("afull_wr_en_held", wr_en, 1'b1);
        check("afull_no_pops", got_q.size(), 0);
        wr_rdy = 1'b1;
        drive_beats(64, 400, 1'b1);
        wait_frame_end(400);
        check_words("f32x4");

        // Reset in the middle of a frame, then a fresh frame
        configure(16, 4, 1'b0);
        clear_sb();
        start_rx(64, lat);
        drive_beats(10, 100, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_no_frame_end", fe_cnt, 0);
        configure(16, 4, 1'b0);
        build_exp(64, 1'b0);
        clear_sb();
        start_rx(64, lat);
        drive_beats(32, 200, 1'b1);
        wait_frame_end(300);
        check_words("post_rst");
        check("post_rst_no_len_err", le_cnt, 0);
`ifdef IMAGE_RX_STATS_EN
        check("post_rst_frame_cnt", frame_cnt, 16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
